// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-lane data memory: access sizes,
// clear/ready states, byte-enable mask and alignment test.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic logic [3:0] be_mask(input size_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    be_mask = 4'b0001 << lane;
      SZ_H:    be_mask = 4'b0011 << lane;
      SZ_W:    be_mask = 4'b1111;
      default: be_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lane[0];
      SZ_W:    misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ld_extract.sv
// Load-path formatter: shifts the addressed byte/half of a read word down to
// bit 0 and sign- or zero-extends it to 32 bits.
module dmem_ld_extract
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;

  always_comb begin
    w_shift = i_word >> {i_lane, 3'b000};
    o_data  = 32'h0;
    case (size_t'(i_size))
      SZ_B:    o_data = i_unsigned ? {24'h0, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_H:    o_data = i_unsigned ? {16'h0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
      SZ_W:    o_data = w_shift;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte/half/word data memory with registered 1-cycle responses. The array is
// split into four byte-wide RAMs and zeroed one word per cycle after reset.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int  DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_clr_idx;
  logic             w_clr_we;

  logic             w_accept;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_wr;
  logic [3:0]       w_be;
  logic [IDX_W-1:0] w_wr_idx;
  logic [31:0]      w_wr_word;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_ext;

  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_rsp_ld;
  logic [1:0]       r_lane;
  logic [1:0]       r_size;
  logic             r_unsigned;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clr_we) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_CLEAR && r_clr_idx == IDX_W'(DEPTH - 1)) w_state_next = ST_READY;
  end

  // State outputs
  always_comb begin
    req_ready = (r_state == ST_READY);
    busy      = (r_state == ST_CLEAR);
    w_clr_we  = (r_state == ST_CLEAR) && !reset;
  end

  assign w_lane   = req_addr[1:0];
  assign w_idx    = req_addr[IDX_W+1:2];
  // High address bits are range-checked rather than masked, so no aliasing.
  assign w_err    = (size_t'(req_size) == SZ_X) || misaligned(size_t'(req_size), w_lane)
                    || (|req_addr[31:IDX_W+2]);
  assign w_accept = req_valid && req_ready && !reset;
  assign w_wr     = w_accept && req_we && !w_err;

  always_comb begin
    w_wr_idx  = w_idx;
    w_wr_word = req_wdata;
    w_be      = 4'b0000;
    if (w_clr_we) begin
      w_wr_idx  = r_clr_idx;
      w_wr_word = 32'h0;
      w_be      = 4'b1111;
    end else if (w_wr) begin
      w_be = be_mask(size_t'(req_size), w_lane);
      case (size_t'(req_size))
        SZ_B:    w_wr_word = {4{req_wdata[7:0]}};
        SZ_H:    w_wr_word = {2{req_wdata[15:0]}};
        default: w_wr_word = req_wdata;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rd_byte;

      always_ff @(posedge clk) begin
        if (w_be[gi]) r_mem[w_wr_idx] <= w_wr_word[8*gi +: 8];
        if (w_accept) r_rd_byte <= r_mem[w_idx];
      end

      assign w_rd_word[8*gi +: 8] = r_rd_byte;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_ld    <= 1'b0;
      r_lane      <= 2'b00;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept && w_err;
      r_rsp_ld    <= w_accept && !req_we && !w_err;
      if (w_accept) begin
        r_lane     <= w_lane;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
      end
    end
  end

  dmem_ld_extract u_ext (
    .i_word     (w_rd_word),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_ld ? w_ext : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_dmem_bytelane;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [NBYTES];

  always #5 clk = ~clk;

  dmem_bytelane #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
  endtask

  // Drops the request lines, waits for the clear to finish (bounded) and
  // reports the number of cycles busy stayed high and any ready/rsp glitch.
  task automatic wait_clear(output int cnt, output logic glitch);
    req_valid = 1'b0;
    cnt = 0;
    glitch = 1'b0;
    while (busy && cnt < 200) begin
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) glitch = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // Presents one request, lets it be accepted, then checks the response
  // against the reference model. Leaves req_valid high for back-to-back use.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, output logic [31:0] got);
    int nb;
    logic exp_err;
    logic [31:0] exp_data;
    longint v;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_err = (size == 2'b11) || ((addr % nb) != 0) || (64'(addr) >= 64'(NBYTES));
    exp_data = 32'h0;
    if (!exp_err && !we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(m_mem[addr + i]) << (8 * i);
      if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
      exp_data = v[31:0];
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready addr=%h got=%b want=1", addr, req_ready);
    end
    @(posedge clk); #1;
    if (!exp_err && we)
      for (int i = 0; i < nb; i++) m_mem[addr + i] = wdata[8*i +: 8];
    got = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_data) begin
      errors++;
      $display("FAIL rsp we=%b addr=%h size=%0d uns=%b got v=%b e=%b d=%h want v=1 e=%b d=%h",
               we, addr, size, uns, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_data);
    end
    $display("txn we=%b addr=%h size=%0d uns=%b wdata=%h -> err=%b rdata=%h",
             we, addr, size, uns, wdata, rsp_err, rsp_rdata);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic glitch;
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals got busy=%b rdy=%b v=%b d=%h e=%b want 1/0/0/0/0",
               busy, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    reset = 1'b0;
    model_clear();
    wait_clear(cnt, glitch);
    checks++;
    if (cnt != DEPTH || glitch) begin
      errors++;
      $display("FAIL clear_len got %0d glitch=%b want %0d glitch=0", cnt, glitch, DEPTH);
    end
    issue(1'b0, 32'h0FC, 2'b10, 1'b0, 32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL load_top got %h want 00000000", d);
    end
    idle();
  endtask

  task automatic test_lanes();
    logic [31:0] d;
    logic [31:0] want [5] = '{32'h5AADBEEF, 32'h0000005A, 32'h00005AAD,
                              32'hFFFFFFBE, 32'h000000BE};
    logic [31:0] got [5];
    issue(1'b1, 32'h010, 2'b10, 1'b0, 32'hDEADBEEF, d);
    issue(1'b1, 32'h013, 2'b00, 1'b0, 32'h0000005A, d);
    issue(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, got[0]);
    issue(1'b0, 32'h013, 2'b00, 1'b0, 32'h0, got[1]);
    issue(1'b0, 32'h012, 2'b01, 1'b0, 32'h0, got[2]);
    issue(1'b0, 32'h011, 2'b00, 1'b0, 32'h0, got[3]);
    issue(1'b0, 32'h011, 2'b00, 1'b1, 32'h0, got[4]);
    idle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL lane_load%0d got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    issue(1'b1, 32'h020, 2'b10, 1'b0, 32'h01234567, d);
    issue(1'b1, 32'h022, 2'b10, 1'b0, 32'hFFFFFFFF, d);
    issue(1'b0, 32'h021, 2'b01, 1'b0, 32'h0, d);
    issue(1'b1, 32'h020, 2'b11, 1'b0, 32'hFFFFFFFF, d);
    issue(1'b1, 32'h100, 2'b10, 1'b0, 32'hFFFFFFFF, d);
    issue(1'b0, 32'h020, 2'b10, 1'b0, 32'h0, d);
    idle();
    checks++;
    if (d !== 32'h01234567) begin
      errors++;
      $display("FAIL err_no_write got %h want 01234567", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    issue(1'b1, 32'h040, 2'b10, 1'b0, 32'h11223344, d);
    issue(1'b0, 32'h040, 2'b10, 1'b0, 32'h0, d);
    idle();
    checks++;
    if (d !== 32'h11223344) begin
      errors++;
      $display("FAIL b2b_load got %h want 11223344", d);
    end
  endtask

  task automatic test_reset_midflight();
    int cnt;
    logic glitch;
    logic [31:0] d;
    issue(1'b1, 32'h008, 2'b10, 1'b0, 32'hCAFEF00D, d);
    req_we = 1'b0; req_addr = 32'h008; req_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_drop got rsp_valid=%b want 0", rsp_valid);
    end
    wait_clear(cnt, glitch);
    checks++;
    if (cnt != DEPTH || glitch) begin
      errors++;
      $display("FAIL reclear_len got %0d glitch=%b want %0d glitch=0", cnt, glitch, DEPTH);
    end
    issue(1'b0, 32'h008, 2'b10, 1'b0, 32'h0, d);
    idle();
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL cleared_word got %h want 00000000", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, addr;
    logic [1:0] size;
    for (int n = 0; n < 300; n++) begin
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 1) == 0)
        addr = addr & ~((size == 2'b00) ? 32'h0 : (size == 2'b01) ? 32'h1 : 32'h3);
      if ($urandom_range(0, 11) == 0) addr = addr | (32'h1 << $urandom_range(8, 31));
      issue(1'($urandom_range(0, 1)), addr, size, 1'($urandom_range(0, 1)), $urandom, d);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
